// File: rtl/floppy_multi_if.sv
// Controller bus between the FDC core / image fetcher side (master) and the
// multi-drive floppy emulator (slave). FLOPPY_DISK_CHANGE_EN adds the disk-change pins.
interface floppy_multi_if #(
   parameter int NUM_DRIVES = 4
);
   logic [NUM_DRIVES-1:0] drive_sel;
   logic [NUM_DRIVES-1:0] motor_on;
   logic [NUM_DRIVES-1:0] wp_in;
   logic                  side;
   logic                  step_in;
   logic                  step_out;
   logic [4:0]            step_rate_ms;
   logic [1:0]            density;
   logic [10:0]           sector_len;
   logic                  sector_base;
   logic [4:0]            spt;
   logic [4:0]            interleave;
   logic [9:0]            sector_gap_len;

   logic                  dclk_en;
   logic [7:0]            track;
   logic [4:0]            sector;
   logic                  side_out;
   logic                  sector_hdr;
   logic                  sector_data;
   logic                  ready;
   logic                  index;
   logic                  track0;
   logic                  wprot;
`ifdef FLOPPY_DISK_CHANGE_EN
   logic [NUM_DRIVES-1:0] img_mounted;
   logic                  dskchg;
`endif

   modport master (
`ifdef FLOPPY_DISK_CHANGE_EN
      output img_mounted,
      input  dskchg,
`endif
      output drive_sel, motor_on, side, step_in, step_out, step_rate_ms, density,
             sector_len, sector_base, spt, interleave, sector_gap_len, wp_in,
      input  dclk_en, track, sector, side_out, sector_hdr, sector_data, ready,
             index, track0, wprot
   );

   modport slave (
`ifdef FLOPPY_DISK_CHANGE_EN
      input  img_mounted,
      output dskchg,
`endif
      input  drive_sel, motor_on, side, step_in, step_out, step_rate_ms, density,
             sector_len, sector_base, spt, interleave, sector_gap_len, wp_in,
      output dclk_en, track, sector, side_out, sector_hdr, sector_data, ready,
             index, track0, wprot
   );
endinterface

// File: rtl/floppy_multi.sv
// Multi-drive floppy emulator: shared byte clock / sector stream, per-drive head and spin-up.
// Optional disk-change latches are enabled by defining FLOPPY_DISK_CHANGE_EN.
module floppy_multi #(
   parameter int NUM_DRIVES  = 4,
   parameter int CLK_HZ      = 42578000,
   parameter int TRACKS      = 80,
   parameter int SPINUP_REVS = 3,
   parameter int INDEX_BYTES = 20,
   parameter int HDR_LEN     = 6
) (
   input logic          clk,
   input logic          reset_n,
   floppy_multi_if.slave bus
);
   localparam int DW     = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
   localparam int RW     = $clog2(SPINUP_REVS + 1);
   localparam int IW     = $clog2(INDEX_BYTES + 1);
   localparam int MS_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 2;
   localparam int MW     = $clog2(MS_DIV);
   localparam logic [31:0] CLK_HZ_W = 32'(CLK_HZ);

   typedef enum logic [1:0] {GAP, HDR, DATA} sec_state_t;

   // Drive select: lowest set bit wins.
   logic [DW-1:0] sel_idx;
   logic          sel_any;
   always_comb begin
      sel_idx = '0;
      sel_any = 1'b0;
      for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
         if (bus.drive_sel[i]) begin
            sel_idx = DW'(i);
            sel_any = 1'b1;
         end
      end
   end

   logic [31:0] acc, br, acc_sum;
   logic [13:0] bpt, byte_cnt;
   logic        motor_any, byte_tick, rev_wrap;
   always_comb begin
      case (bus.density)
         2'd0:    begin br = 32'd15625; bpt = 14'd3125;  end
         2'd1:    begin br = 32'd31250; bpt = 14'd6250;  end
         default: begin br = 32'd62500; bpt = 14'd12500; end
      endcase
   end
   assign motor_any = |bus.motor_on;
   assign acc_sum   = acc + br;
   assign byte_tick = motor_any && (acc_sum >= CLK_HZ_W);
   // >= rather than == so a density drop past the new end still wraps next byte.
   assign rev_wrap  = byte_tick && (byte_cnt >= bpt - 14'd1);

   logic [IW-1:0] idx_cnt;
   logic [MW-1:0] ms_cnt;
   logic          ms_tick;
   logic          step_in_q, step_in_qq, step_out_q, step_out_qq, in_edge, out_edge;
   assign ms_tick  = (ms_cnt == MW'(MS_DIV - 1));
   assign in_edge  = step_in_q & ~step_in_qq;
   assign out_edge = step_out_q & ~step_out_qq;

   sec_state_t  state_q, state_d;
   logic [10:0] rem_q, rem_d, gap_full;
   logic [4:0]  sector_q, sector_d, base_id;
   logic [5:0]  sec_off, sec_next;
   assign gap_full = {1'b0, bus.sector_gap_len} - 11'd1;
   assign base_id  = {4'd0, bus.sector_base};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      sector_d = sector_q;
      sec_off  = {1'b0, sector_q} - {1'b0, base_id} + {1'b0, bus.interleave};
      sec_next = (sec_off >= {1'b0, bus.spt}) ? sec_off - {1'b0, bus.spt} : sec_off;
      if (rev_wrap) begin
         state_d  = GAP;
         rem_d    = gap_full;
         sector_d = base_id;
      end else if (byte_tick) begin
         if (rem_q != 11'd0) begin
            rem_d = rem_q - 11'd1;
         end else begin
            case (state_q)
               GAP: begin
                  state_d = HDR;
                  rem_d   = 11'(HDR_LEN - 1);
               end
               HDR: begin
                  state_d = DATA;
                  rem_d   = bus.sector_len - 11'd1;
               end
               default: begin
                  state_d  = GAP;
                  rem_d    = gap_full;
                  sector_d = sec_next[4:0] + base_id;
               end
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc         <= '0;
         byte_cnt    <= '0;
         idx_cnt     <= '0;
         ms_cnt      <= '0;
         step_in_q   <= 1'b0;
         step_in_qq  <= 1'b0;
         step_out_q  <= 1'b0;
         step_out_qq <= 1'b0;
         state_q     <= GAP;
         rem_q       <= gap_full;
         sector_q    <= base_id;
      end else begin
         if (motor_any) acc <= byte_tick ? acc_sum - CLK_HZ_W : acc_sum;
         if (rev_wrap)       byte_cnt <= '0;
         else if (byte_tick) byte_cnt <= byte_cnt + 14'd1;
         if (rev_wrap)                           idx_cnt <= IW'(INDEX_BYTES);
         else if (byte_tick && idx_cnt != '0)    idx_cnt <= idx_cnt - IW'(1);
         ms_cnt      <= ms_tick ? '0 : ms_cnt + MW'(1);
         step_in_q   <= bus.step_in;
         step_in_qq  <= step_in_q;
         step_out_q  <= bus.step_out;
         step_out_qq <= step_out_q;
         state_q     <= state_d;
         rem_q       <= rem_d;
         sector_q    <= sector_d;
      end
   end

   logic [7:0]    trk_q  [NUM_DRIVES];
   logic [RW-1:0] rev_q  [NUM_DRIVES];
   logic [4:0]    busy_q [NUM_DRIVES];

   // NOTE: the per-drive arrays are small register files, not RAM, so they are reset explicitly.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            trk_q[i]  <= '0;
            rev_q[i]  <= '0;
            busy_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (!bus.motor_on[i])                               rev_q[i] <= '0;
            else if (rev_wrap && rev_q[i] != RW'(SPINUP_REVS))  rev_q[i] <= rev_q[i] + RW'(1);
            if (sel_any && sel_idx == DW'(i) && (in_edge || out_edge)) begin
               busy_q[i] <= bus.step_rate_ms;
               if (in_edge && !out_edge && trk_q[i] != 8'd0)
                  trk_q[i] <= trk_q[i] - 8'd1;
               else if (out_edge && !in_edge && trk_q[i] != 8'(TRACKS - 1))
                  trk_q[i] <= trk_q[i] + 8'd1;
            end else if (ms_tick && busy_q[i] != 5'd0) begin
               busy_q[i] <= busy_q[i] - 5'd1;
            end
         end
      end
   end

   assign bus.sector      = sector_q;
   assign bus.sector_hdr  = (state_q == HDR);
   assign bus.sector_data = (state_q == DATA);
   assign bus.index       = (idx_cnt != '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.dclk_en  <= 1'b0;
         bus.side_out <= 1'b0;
         bus.track    <= '0;
         bus.track0   <= 1'b0;
         bus.wprot    <= 1'b0;
         bus.ready    <= 1'b0;
      end else begin
         bus.dclk_en  <= byte_tick;
         bus.side_out <= bus.side;
         bus.track    <= sel_any ? trk_q[sel_idx] : 8'd0;
         bus.track0   <= sel_any && (trk_q[sel_idx] == 8'd0);
         bus.wprot    <= sel_any && bus.wp_in[sel_idx];
         // motor_on is looked at directly so ready drops on the same edge the rev counter clears.
         bus.ready    <= sel_any && bus.motor_on[sel_idx] &&
                         (rev_q[sel_idx] == RW'(SPINUP_REVS)) && (busy_q[sel_idx] == 5'd0);
      end
   end

`ifdef FLOPPY_DISK_CHANGE_EN
   logic [NUM_DRIVES-1:0] chg_q;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chg_q      <= '1;
         bus.dskchg <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (bus.img_mounted[i])
               chg_q[i] <= 1'b1;
            else if (sel_any && sel_idx == DW'(i) && (in_edge || out_edge))
               chg_q[i] <= 1'b0;
         end
         bus.dskchg <= sel_any && chg_q[sel_idx];
      end
   end
`endif
endmodule

// File: tb/tb_floppy_multi.sv
// Self-checking bench for floppy_multi: sector IDs are scoreboarded from a small model,
// timing, stepping, selection, spin-up and reset behaviour are checked directly.
module tb_floppy_multi;
   localparam int ND      = 4;
   localparam int CLK_HZ  = 37500;
   localparam int MS_CLKS = CLK_HZ / 1000;
   localparam int HDR_LEN = 6;
   localparam int SEC_LEN = 8;
   localparam int GAP_LEN = 4;
   localparam int SPT     = 5;
   localparam int BASE    = 1;
   localparam int IL      = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   floppy_multi_if #(.NUM_DRIVES(ND)) bus ();
   floppy_multi #(.NUM_DRIVES(ND), .CLK_HZ(CLK_HZ), .HDR_LEN(HDR_LEN)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Sector-ID scoreboard: stimulus pushes model IDs, monitor pops on each header start.
   int   exp_q[$];
   bit   armed = 1'b0;
   int   gap_n = 0, hdr_n = 0, dat_n = 0;
   logic idx_p = 1'b0, hdr_p = 1'b0, dat_p = 1'b0;

   always @(negedge clk) begin
      if (!reset_n) begin
         armed = 1'b0;
      end else begin
         if (bus.index && !idx_p) begin
            gap_n = 0; hdr_n = 0; dat_n = 0;
            armed = (exp_q.size() > 0);
         end
         if (bus.dclk_en) begin
            if (bus.sector_hdr)       hdr_n++;
            else if (bus.sector_data) dat_n++;
            else                      gap_n++;
         end
         if (armed) begin
            if (bus.sector_hdr && !hdr_p) begin
               check("gap_len", gap_n, GAP_LEN);
               check("sector_id", bus.sector, exp_q.pop_front());
               gap_n = 0;
               armed = (exp_q.size() > 0);
            end
            if (!bus.sector_hdr && hdr_p) begin
               check("hdr_len", hdr_n, HDR_LEN);
               hdr_n = 0;
            end
            if (!bus.sector_data && dat_p) begin
               check("data_len", dat_n, SEC_LEN);
               dat_n = 0;
            end
         end
      end
      idx_p = bus.index;
      hdr_p = bus.sector_hdr;
      dat_p = bus.sector_data;
   end

   task automatic wait_index_rise(input string tag);
      logic prev;
      bit   hit = 1'b0;
      for (int n = 0; n < 20000 && !hit; n++) begin
         prev = bus.index;
         @(negedge clk);
         hit = bus.index && !prev;
      end
      check(tag, hit, 1);
   endtask

   // mode: 0 = step_in, 1 = step_out, 2 = both in the same clock
   task automatic step_pulse(input int mode);
      @(negedge clk);
      bus.step_in  = (mode != 1);
      bus.step_out = (mode != 0);
      repeat (3) @(negedge clk);
      bus.step_in  = 1'b0;
      bus.step_out = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dclk"},   bus.dclk_en, 0);
      check({tag, "_track"},  bus.track, 0);
      check({tag, "_sector"}, bus.sector, BASE);
      check({tag, "_side"},   bus.side_out, 0);
      check({tag, "_hdr"},    bus.sector_hdr, 0);
      check({tag, "_data"},   bus.sector_data, 0);
      check({tag, "_ready"},  bus.ready, 0);
      check({tag, "_index"},  bus.index, 0);
      check({tag, "_trk0"},   bus.track0, 0);
      check({tag, "_wprot"},  bus.wprot, 0);
`ifdef FLOPPY_DISK_CHANGE_EN
      check({tag, "_dskchg"}, bus.dskchg, 0);
`endif
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, per, hi, t, s;
      bit hit;
      logic prev;

      bus.drive_sel = 4'b0001;  bus.motor_on = 4'b0011;  bus.wp_in = 4'b0100;
      bus.side = 1'b1;          bus.step_in = 1'b0;      bus.step_out = 1'b0;
      bus.step_rate_ms = 5'd3;  bus.density = 2'd1;      bus.sector_len = 11'(SEC_LEN);
      bus.sector_base = 1'(BASE); bus.spt = 5'(SPT);     bus.interleave = 5'(IL);
      bus.sector_gap_len = 10'(GAP_LEN);
`ifdef FLOPPY_DISK_CHANGE_EN
      bus.img_mounted = '0;
`endif
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("side_out", bus.side_out, 1);
      check("trk0_init", bus.track0, 1);
      check("ready_cold", bus.ready, 0);

      // DD at CLK_HZ = 1.2 * 31250: five strobes per six clocks.
      cnt = 0;
      repeat (3000) begin
         @(negedge clk);
         if (bus.dclk_en) cnt++;
      end
      check("dclk_rate", cnt, 2500);

      s = BASE;
      for (int k = 0; k < 6; k++) begin
         exp_q.push_back(s);
         s = ((s - BASE + IL) % SPT) + BASE;
      end

      wait_index_rise("index1");
      per = 1; hi = 1; hit = 1'b0;
      for (int n = 0; n < 20000 && !hit; n++) begin
         prev = bus.index;
         @(negedge clk);
         hit = bus.index && !prev;
         if (!hit && bus.dclk_en) begin
            per++;
            if (bus.index) hi++;
         end
      end
      check("index2", hit, 1);
      check("rev_bytes", per, 6250);
      check("index_bytes", hi, 20);
      check("sectors_seen", exp_q.size(), 0);
      check("ready_2rev", bus.ready, 0);
      wait_index_rise("index3");
      check("ready_at_3rd", bus.ready, 0);
      repeat (2) @(negedge clk);
      check("ready_spun", bus.ready, 1);

      // Drive 1: clamp at track 0, then seek outward with a 3 ms settle.
      bus.drive_sel = 4'b0010;
      repeat (2) @(negedge clk);
      check("d1_ready", bus.ready, 1);
      repeat (3) step_pulse(0);
      check("d1_clamp0", bus.track, 0);
      check("d1_trk0", bus.track0, 1);
      repeat (5) step_pulse(1);
      check("d1_track5", bus.track, 5);
      check("d1_trk0_off", bus.track0, 0);
      check("d1_busy", bus.ready, 0);
      t = 0;
      while (!bus.ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("d1_settle_window", (4 + t >= 2 * MS_CLKS) && (4 + t <= 3 * MS_CLKS + 2), 1);
      step_pulse(2);
      check("d1_both_edges", bus.track, 5);
      check("d1_both_busy", bus.ready, 0);

      // Drive 2 to track 7, then select changes.
      bus.step_rate_ms = 5'd0;
      bus.drive_sel = 4'b0100;
      repeat (7) step_pulse(1);
      check("d2_track7", bus.track, 7);
      check("d2_wprot", bus.wprot, 1);
      check("d2_no_motor", bus.ready, 0);
      bus.drive_sel = 4'b0001;
      bus.side = 1'b0;
      @(negedge clk);
      check("d0_track", bus.track, 0);
      check("d0_trk0", bus.track0, 1);
      check("d0_wprot", bus.wprot, 0);
      check("side_low", bus.side_out, 0);
      bus.drive_sel = 4'b0100;
      @(negedge clk);
      check("d2_reselect", bus.track, 7);
      bus.drive_sel = 4'b0000;
      @(negedge clk);
      check("none_track", bus.track, 0);
      check("none_wprot", bus.wprot, 0);
      check("none_trk0", bus.track0, 0);
      bus.drive_sel = 4'b0110;
      @(negedge clk);
      check("lowest_wins", bus.track, 5);

      // Drive 3: clamp at the outermost track.
      bus.drive_sel = 4'b1000;
      repeat (85) step_pulse(1);
      check("d3_clamp_hi", bus.track, 79);

      // Motor drop and re-spin on drive 0.
      bus.drive_sel = 4'b0001;
      repeat (2) @(negedge clk);
      check("d0_ready", bus.ready, 1);
      bus.motor_on = 4'b0010;
      @(negedge clk);
      check("motor_drop", bus.ready, 0);
      bus.motor_on = 4'b0011;
      wait_index_rise("respin1");
      wait_index_rise("respin2");
      check("respin_2rev", bus.ready, 0);
      wait_index_rise("respin3");
      check("respin_at_3rd", bus.ready, 0);
      repeat (2) @(negedge clk);
      check("respin_ready", bus.ready, 1);

      // Reset in the middle of a data field.
      bus.drive_sel = 4'b1000;
      t = 0;
      while (!bus.sector_data && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("reach_data", bus.sector_data, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      check("d3_after_rst", bus.track, 0);
      check("d3_trk0_rst", bus.track0, 1);
`ifdef FLOPPY_DISK_CHANGE_EN
      check("dskchg_after_rst", bus.dskchg, 1);
      step_pulse(1);
      check("dskchg_cleared", bus.dskchg, 0);
      @(negedge clk);
      bus.img_mounted = 4'b1000;
      @(negedge clk);
      bus.img_mounted = 4'b0000;
      repeat (2) @(negedge clk);
      check("dskchg_mount", bus.dskchg, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
